aplic_gateway: RTL and testbench
================================

APLIC_GATEWAY -- requirements
Module: aplic_gateway

Interface
REQ-001 SHALL have parameter NR_SRC, default 32, giving the source count; source 0 does not exist and bit 0 of every vector is unused.
REQ-002 SHALL have parameter SRC_W, default $clog2(NR_SRC), giving the source-identity width.
REQ-003 SHALL use one clock and a synchronous active-high reset, with ports i_clk and i_rst; all other ports follow.
REQ-004 i_clk  input  1  block clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_irq_sources  input  NR_SRC  source lines, already 2-flop synchronized to i_clk.
REQ-007 i_sourcecfg  input  NR_SRC*3  per-source mode field, bits [3i+2:3i]; 0=inactive, 1=detached, 4=edge1, 5=edge0, 6=level1, 7=level0; 2 and 3 are treated as inactive.
REQ-008 i_setip  input  NR_SRC  one-cycle software set-pending strobes (setip/setipnum writes).
REQ-009 i_clrip  input  NR_SRC  one-cycle software clear-pending strobes (in_clrip/clripnum writes).
REQ-010 i_claim_valid  input  1  one-cycle claim strobe (claimi read).
REQ-011 i_claim_id  input  SRC_W  source being claimed.
REQ-012 o_pending  output  NR_SRC  registered pending bits.
REQ-013 o_rectified  output  NR_SRC  rectified input values (in_clrip readback); combinational.

Function
REQ-014 Rectified value: edge1/level1 = raw input; edge0/level0 = inverted raw input; inactive/detached/reserved = 0.
REQ-015 A per-source register prev SHALL capture the raw i_irq_sources every cycle, regardless of mode.
REQ-016 Edge event for edge1 SHALL be prev=0 and raw=1; edge event for edge0 SHALL be prev=1 and raw=0. A mode change alone SHALL never produce an edge event.
REQ-017 Edge modes: pending SHALL set on an edge event or i_setip, and SHALL clear on i_clrip or a matching claim.
REQ-018 Level modes: i_setip and i_clrip SHALL be ignored; pending SHALL set when rectified=1; a matching claim SHALL clear pending; pending SHALL also clear whenever rectified=0.
REQ-019 Detached mode: pending SHALL change only via i_setip, i_clrip or a matching claim.
REQ-020 Inactive and reserved modes: pending SHALL be forced to 0 on the next edge, overriding all set sources.
REQ-021 Same-cycle set and clear on one source: set SHALL win. This covers hardware edge vs claim, i_setip vs i_clrip, and level-high vs claim.
REQ-022 A matching claim SHALL require i_claim_valid=1 and i_claim_id=i. i_claim_id=0 or i_claim_id>=NR_SRC SHALL have no effect.
REQ-023 Latency: an event sampled at edge n SHALL appear on o_pending after edge n; o_pending SHALL be registered with no combinational path from any input.
REQ-024 Bit 0 of o_pending, o_rectified and prev SHALL be constant 0.
REQ-025 Sources SHALL be updated independently; simultaneous events on different sources SHALL all take effect in the same cycle.

Reset
REQ-026 With i_rst=1 at a clock edge, o_pending and prev SHALL become 0; this SHALL hold for reset asserted mid-operation.
REQ-027 In the first cycle after reset, a source already held high SHALL not create an edge1 event, because prev is loaded from the raw input at that cycle's edge.
REQ-028 In the first cycle after reset, a source already held high SHALL set a level1 pending bit.

Verification
REQ-029 Edge1, source 3: raw 0->1 at cycle 5 -> o_pending[3]=1 from cycle 6; raw held high -> no re-trigger after i_clrip[3].
REQ-030 Level0, source 7: raw=0 -> pending=1; i_setip[7] and i_clrip[7] ignored; claim of id 7 with raw still 0 -> pending stays 1; raw=1 -> pending=0 next cycle.
REQ-031 Edge1, source 5: claim of id 5 in the same cycle as a new rising edge -> o_pending[5] remains 1.
REQ-032 Detached, source 2: raw toggles -> o_pending[2]=0 and o_rectified[2]=0; i_setip[2] -> pending=1; i_setip[2] and i_clrip[2] together -> pending=1.
REQ-033 Source 4: pending=1 in edge0, then mode written to 0 -> o_pending[4]=0 next cycle; mode changed edge1->edge0 with raw steady -> no pending.
REQ-034 i_rst pulsed for 1 cycle with all pending bits set -> o_pending=0; claim of id 0 or id >= NR_SRC -> no bit changes.

Source files
------------

// File: rtl/aplic_gateway.sv
`default_nettype none
// ============================================================================
//  Module      : aplic_gateway
//  Description : APLIC interrupt gateway. Rectifies each source line according
//                to its configured mode, detects edges against a per-source
//                history register and maintains the registered pending bits
//                (hardware set, software set/clear and claim clear).
//  Ports       : i_clk          block clock
//                i_rst          synchronous active-high reset
//                i_irq_sources  raw source lines (already synchronized)
//                i_sourcecfg    3-bit mode field per source
//                i_setip        one-cycle software set-pending strobes
//                i_clrip        one-cycle software clear-pending strobes
//                i_claim_valid  one-cycle claim strobe
//                i_claim_id     identity of the source being claimed
//                o_pending      registered pending bits
//                o_rectified    combinational rectified input values
//  Revision    : 1.0 - initial release
// ============================================================================
module aplic_gateway #(
    parameter int NR_SRC = 32,
    parameter int SRC_W  = $clog2(NR_SRC)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NR_SRC-1:0]     i_irq_sources,
    input  logic [NR_SRC*3-1:0]   i_sourcecfg,
    input  logic [NR_SRC-1:0]     i_setip,
    input  logic [NR_SRC-1:0]     i_clrip,
    input  logic                  i_claim_valid,
    input  logic [SRC_W-1:0]      i_claim_id,
    output logic [NR_SRC-1:0]     o_pending,
    output logic [NR_SRC-1:0]     o_rectified
);

    localparam logic [2:0] c_MODE_DETACHED = 3'd1;
    localparam logic [2:0] c_MODE_EDGE1    = 3'd4;
    localparam logic [2:0] c_MODE_EDGE0    = 3'd5;
    localparam logic [2:0] c_MODE_LEVEL1   = 3'd6;
    localparam logic [2:0] c_MODE_LEVEL0   = 3'd7;

    logic [NR_SRC-1:0] r_pending;
    logic [NR_SRC-1:0] r_prev;
    logic [NR_SRC-1:0] w_pending_nxt;
    logic [NR_SRC-1:0] w_rectified;
    // Low for exactly the first cycle after reset. r_prev is 0 out of reset,
    // so without this mask a line already held high would look like a fresh
    // edge; the mask makes that cycle behave as if r_prev had been loaded
    // from the raw input.
    logic              r_armed;

    // Source 0 does not exist.
    assign w_rectified[0]   = 1'b0;
    assign w_pending_nxt[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NR_SRC; gi++) begin : g_src
            logic [2:0] w_mode;
            logic       w_raw;
            logic       w_claim;
            logic       w_rect;
            logic       w_edge;
            logic       w_set;
            logic       w_clr;
            logic       w_nxt;

            assign w_mode  = i_sourcecfg[3*gi +: 3];
            assign w_raw   = i_irq_sources[gi];
            assign w_claim = i_claim_valid && (i_claim_id == SRC_W'(gi));

            always_comb begin
                w_rect = 1'b0;
                w_edge = 1'b0;
                w_set  = 1'b0;
                w_clr  = 1'b0;
                w_nxt  = 1'b0;
                case (w_mode)
                    c_MODE_EDGE1: begin
                        w_rect = w_raw;
                        // Edge is taken from the raw history, so changing the
                        // mode alone can never fabricate an event.
                        w_edge = r_armed & ~r_prev[gi] & w_raw;
                        w_set  = w_edge | i_setip[gi];
                        w_clr  = i_clrip[gi] | w_claim;
                        w_nxt  = w_set | (r_pending[gi] & ~w_clr);
                    end
                    c_MODE_EDGE0: begin
                        w_rect = ~w_raw;
                        w_edge = r_armed & r_prev[gi] & ~w_raw;
                        w_set  = w_edge | i_setip[gi];
                        w_clr  = i_clrip[gi] | w_claim;
                        w_nxt  = w_set | (r_pending[gi] & ~w_clr);
                    end
                    c_MODE_LEVEL1, c_MODE_LEVEL0: begin
                        w_rect = (w_mode == c_MODE_LEVEL1) ? w_raw : ~w_raw;
                        // Active level sets (and beats a claim); inactive level
                        // clears. Software strobes are ignored, so pending
                        // simply follows the rectified value.
                        w_nxt  = w_rect;
                    end
                    c_MODE_DETACHED: begin
                        w_set  = i_setip[gi];
                        w_clr  = i_clrip[gi] | w_claim;
                        w_nxt  = w_set | (r_pending[gi] & ~w_clr);
                    end
                    default: begin
                        // Inactive and reserved encodings hold pending at 0.
                        w_nxt  = 1'b0;
                    end
                endcase
            end

            assign w_rectified[gi]   = w_rect;
            assign w_pending_nxt[gi] = w_nxt;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
            r_prev    <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_prev    <= {i_irq_sources[NR_SRC-1:1], 1'b0};
            r_armed   <= 1'b1;
        end
    end

    assign o_pending   = r_pending;
    assign o_rectified = w_rectified;

    // Bit 0 of each per-source vector carries no source.
    logic w_unused;
    assign w_unused = ^{i_irq_sources[0], i_sourcecfg[2:0], i_setip[0],
                        i_clrip[0], r_prev[0]};

endmodule
`default_nettype wire

// File: tb/tb_aplic_gateway.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aplic_gateway
//  Description : Self-checking bench for aplic_gateway. Each cycle the bench
//                pushes the expected pending vector into a scoreboard queue,
//                and pops/compares it once the DUT has registered the result.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aplic_gateway;

    localparam int NR = 24;
    localparam int SW = $clog2(NR);

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   raw;
    logic [NR*3-1:0] cfg;
    logic [NR-1:0]   setip;
    logic [NR-1:0]   clrip;
    logic            cv;
    logic [SW-1:0]   cid;
    logic [NR-1:0]   pend;
    logic [NR-1:0]   rect;

    always #5 clk = ~clk;

    aplic_gateway #(
        .NR_SRC (NR),
        .SRC_W  (SW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_irq_sources (raw),
        .i_sourcecfg   (cfg),
        .i_setip       (setip),
        .i_clrip       (clrip),
        .i_claim_valid (cv),
        .i_claim_id    (cid),
        .o_pending     (pend),
        .o_rectified   (rect)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] b(input int s);
        return 32'd1 << s;
    endfunction

    task automatic set_mode(input int s, input logic [2:0] m);
        cfg[3*s +: 3] = m;
    endtask

    task automatic claim(input int id);
        cv  = 1'b1;
        cid = SW'(id);
    endtask

    // Expected value is queued as the stimulus is committed, then popped and
    // compared one clock edge later when the DUT has registered it.
    task automatic tick(input string tag);
        exp_t e;
        e.tag = tag;
        e.exp = exp_pend;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty got %h expected entry", tag, pend);
        end else begin
            e = sb.pop_front();
            check(e.tag, 32'(pend), e.exp);
        end
        setip = '0;
        clrip = '0;
        cv    = 1'b0;
        cid   = '0;
    endtask

    task automatic chk_rect(input string tag, input logic [31:0] exp);
        #1;
        check(tag, 32'(rect), exp);
    endtask

    initial begin
        rst   = 1'b1;
        raw   = '0;
        cfg   = '0;
        setip = '0;
        clrip = '0;
        cv    = 1'b0;
        cid   = '0;
        exp_pend = '0;
        repeat (2) @(posedge clk);
        #1;
        tick("reset");
        chk_rect("rect_reset", 32'd0);

        // Configure and release reset.
        set_mode(2, 3'd1);
        set_mode(3, 3'd4);
        set_mode(4, 3'd5);
        set_mode(5, 3'd4);
        set_mode(7, 3'd7);
        rst = 1'b0;
        chk_rect("rect_cfg", b(7) | b(4));
        exp_pend = b(7);
        tick("lvl0_set");

        // Edge1 on source 3.
        raw[3] = 1'b1;
        exp_pend |= b(3);
        tick("e1_rise");
        tick("e1_hold");
        clrip[3] = 1'b1;
        exp_pend &= ~b(3);
        tick("e1_clr");
        tick("e1_noretrig");

        // Level0 on source 7.
        setip[7] = 1'b1;
        tick("lvl_setip_ign");
        clrip[7] = 1'b1;
        tick("lvl_clrip_ign");
        claim(7);
        tick("lvl_claim_held");
        raw[7] = 1'b1;
        chk_rect("rect_lvl_off", b(3) | b(4));
        exp_pend &= ~b(7);
        tick("lvl_inactive");

        // Edge vs claim on source 5.
        raw[5] = 1'b1;
        exp_pend |= b(5);
        tick("e5_rise");
        raw[5] = 1'b0;
        tick("e5_fall");
        raw[5] = 1'b1;
        claim(5);
        tick("e5_edge_beats_claim");
        claim(5);
        exp_pend &= ~b(5);
        tick("e5_claim");

        // Detached source 2.
        raw[2] = 1'b1;
        chk_rect("rect_detached", b(3) | b(4) | b(5));
        tick("det_raw_hi");
        raw[2] = 1'b0;
        tick("det_raw_lo");
        setip[2] = 1'b1;
        exp_pend |= b(2);
        tick("det_setip");
        clrip[2] = 1'b1;
        exp_pend &= ~b(2);
        tick("det_clrip");
        setip[2] = 1'b1;
        clrip[2] = 1'b1;
        exp_pend |= b(2);
        tick("det_set_wins");
        claim(2);
        exp_pend &= ~b(2);
        tick("det_claim");

        // Edge0 and mode changes on source 4.
        raw[4] = 1'b1;
        tick("e0_rise_ign");
        raw[4] = 1'b0;
        exp_pend |= b(4);
        tick("e0_fall");
        set_mode(4, 3'd0);
        exp_pend &= ~b(4);
        tick("inactive_clear");
        raw[4] = 1'b1;
        tick("inactive_raw");
        set_mode(4, 3'd4);
        tick("mode_e1_steady");
        set_mode(4, 3'd5);
        tick("mode_e0_steady");
        set_mode(4, 3'd0);
        setip[4] = 1'b1;
        tick("inactive_setip");
        set_mode(4, 3'd2);
        setip[4] = 1'b1;
        tick("reserved_setip");

        // Simultaneous events on several sources.
        raw[5] = 1'b0;
        tick("e5_fall2");
        raw[5]   = 1'b1;
        setip[2] = 1'b1;
        exp_pend |= b(5) | b(2);
        tick("multi_src");
        raw[7]   = 1'b0;
        setip[3] = 1'b1;
        exp_pend |= b(7) | b(3);
        tick("multi_src2");

        // Out-of-range claims.
        claim(0);
        tick("claim_id0");
        claim(24);
        tick("claim_id24");
        claim(31);
        tick("claim_id31");

        // Level1 source, then reset mid-operation.
        set_mode(6, 3'd6);
        raw[6] = 1'b1;
        exp_pend |= b(6);
        tick("lvl1_set");
        rst = 1'b1;
        exp_pend = '0;
        tick("mid_reset");
        rst = 1'b0;
        exp_pend = b(6) | b(7);
        tick("post_reset_first");
        tick("post_reset_second");

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
